// File: rtl/pong_ball_engine_pkg.sv
// Shared constants, state encoding and speed table for the PONG ball engine.
package pong_ball_engine_pkg;

  localparam int unsigned H_RES          = 1024;
  localparam int unsigned V_RES          = 768;
  localparam int unsigned BALL_SIZE      = 16;
  localparam int unsigned PADDLE_W       = 16;
  localparam int unsigned PADDLE_H       = 128;
  localparam int unsigned LEFT_PADDLE_X  = 32;
  localparam int unsigned RIGHT_PADDLE_X = 976;

  localparam int unsigned POS_W   = 11;
  localparam int unsigned ARITH_W = 12;

  // Contact planes, wall limits and serve position
  localparam int unsigned LX       = LEFT_PADDLE_X + PADDLE_W;
  localparam int unsigned RX       = RIGHT_PADDLE_X - BALL_SIZE;
  localparam int unsigned X_LIMIT  = H_RES - BALL_SIZE;
  localparam int unsigned Y_LIMIT  = V_RES - BALL_SIZE;
  localparam int unsigned X_CENTRE = (H_RES - BALL_SIZE) / 2;
  localparam int unsigned Y_CENTRE = (V_RES - BALL_SIZE) / 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_STEP_Y     = 3'd2,
    ST_STEP_X     = 3'd3,
    ST_SCORED     = 3'd4
  } state_t;

  // Per-frame step in px: 0->2, 1->4, 2->6, 3->8
  function automatic logic [ARITH_W-1:0] step_px(input logic [1:0] sel);
    return ARITH_W'({sel, 1'b0}) + ARITH_W'(2);
  endfunction

endpackage

// File: rtl/pong_ball_engine_edge_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module pong_ball_engine_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise_c
);

  logic sig_d;

  // History register for the sampled level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_d <= 1'b0;
    else        sig_d <= sig;
  end

  assign rise_c = sig & ~sig_d;

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame ball sequencer: wall bounces, palette hits and misses, score pulses.
module pong_ball_engine
  import pong_ball_engine_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             game_en,
  input  logic             serve,
  input  logic [1:0]       speed_sel,
  input  logic [POS_W-1:0] left_palette_pos,
  input  logic [POS_W-1:0] right_palette_pos,
  output logic [POS_W-1:0] ball_xpos,
  output logic [POS_W-1:0] ball_ypos,
  output logic             score_left,
  output logic             score_right,
  output logic             in_play
);

  localparam logic [ARITH_W-1:0] C_LX      = ARITH_W'(LX);
  localparam logic [ARITH_W-1:0] C_RX      = ARITH_W'(RX);
  localparam logic [ARITH_W-1:0] C_X_LIMIT = ARITH_W'(X_LIMIT);
  localparam logic [ARITH_W-1:0] C_Y_LIMIT = ARITH_W'(Y_LIMIT);
  localparam logic [ARITH_W-1:0] C_BALL    = ARITH_W'(BALL_SIZE);
  localparam logic [ARITH_W-1:0] C_PH      = ARITH_W'(PADDLE_H);
  localparam logic [POS_W-1:0]   C_X_CTR   = POS_W'(X_CENTRE);
  localparam logic [POS_W-1:0]   C_Y_CTR   = POS_W'(Y_CENTRE);

  logic frame_tick_c;

  pong_ball_engine_edge_detect u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig    (vsync),
    .rise_c (frame_tick_c)
  );

  state_t               state_q, state_d;
  logic                 dir_x_q, dir_x_d;   // 1 = moving right
  logic                 dir_y_q, dir_y_d;   // 1 = moving down
  logic [ARITH_W-1:0]   step_q, step_d, step_now;
  logic [POS_W-1:0]     x_d, y_d;
  logic                 score_left_d, score_right_d;
  logic [ARITH_W-1:0]   x_ext, y_ext, lp_ext, rp_ext;
  logic                 overlap_l, overlap_r;

  assign step_now = step_px(speed_sel);
  assign x_ext    = ARITH_W'(ball_xpos);
  assign y_ext    = ARITH_W'(ball_ypos);
  assign lp_ext   = ARITH_W'(left_palette_pos);
  assign rp_ext   = ARITH_W'(right_palette_pos);

  // Vertical overlap with each palette, evaluated on the already-updated y
  assign overlap_l = (y_ext + C_BALL > lp_ext) && (y_ext < lp_ext + C_PH);
  assign overlap_r = (y_ext + C_BALL > rp_ext) && (y_ext < rp_ext + C_PH);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    x_d           = ball_xpos;
    y_d           = ball_ypos;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    step_d        = step_q;
    score_left_d  = 1'b0;
    score_right_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        x_d = C_X_CTR;
        y_d = C_Y_CTR;
        if (serve && game_en) state_d = ST_WAIT_FRAME;
      end

      ST_WAIT_FRAME: begin
        if (frame_tick_c && game_en) state_d = ST_STEP_Y;
      end

      ST_STEP_Y: begin
        step_d  = step_now;
        state_d = ST_STEP_X;
        if (dir_y_q) begin
          if (y_ext + step_now >= C_Y_LIMIT) begin
            y_d     = POS_W'(C_Y_LIMIT);
            dir_y_d = 1'b0;
          end else begin
            y_d = POS_W'(y_ext + step_now);
          end
        end else begin
          if (y_ext <= step_now) begin
            y_d     = '0;
            dir_y_d = 1'b1;
          end else begin
            y_d = POS_W'(y_ext - step_now);
          end
        end
      end

      ST_STEP_X: begin
        state_d = ST_WAIT_FRAME;
        if (dir_x_q) begin
          if ((x_ext <= C_RX) && (x_ext + step_q >= C_RX) && overlap_r) begin
            x_d     = POS_W'(C_RX);
            dir_x_d = 1'b0;
          end else if (x_ext + step_q >= C_X_LIMIT) begin
            state_d      = ST_SCORED;
            score_left_d = 1'b1;
          end else begin
            x_d = POS_W'(x_ext + step_q);
          end
        end else begin
          // A ball already behind the plane fails the first term and always scores
          if ((x_ext >= C_LX) && (x_ext - step_q <= C_LX) && overlap_l) begin
            x_d     = POS_W'(C_LX);
            dir_x_d = 1'b1;
          end else if (x_ext < step_q) begin
            state_d       = ST_SCORED;
            score_right_d = 1'b1;
          end else begin
            x_d = POS_W'(x_ext - step_q);
          end
        end
      end

      ST_SCORED: begin
        // Relaunch back the way the ball came from
        x_d     = C_X_CTR;
        y_d     = C_Y_CTR;
        dir_x_d = ~dir_x_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, direction, step and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      step_q      <= ARITH_W'(2);
      ball_xpos   <= C_X_CTR;
      ball_ypos   <= C_Y_CTR;
      score_left  <= 1'b0;
      score_right <= 1'b0;
      in_play     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      step_q      <= step_d;
      ball_xpos   <= x_d;
      ball_ypos   <= y_d;
      score_left  <= score_left_d;
      score_right <= score_right_d;
      in_play     <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: per-frame expected ball state from a reference model.
module tb_pong_ball_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        game_en;
  logic        serve;
  logic [1:0]  speed_sel;
  logic [10:0] left_palette_pos;
  logic [10:0] right_palette_pos;
  logic [10:0] ball_xpos;
  logic [10:0] ball_ypos;
  logic        score_left;
  logic        score_right;
  logic        in_play;

  always #5 clk = ~clk;

  pong_ball_engine dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .vsync             (vsync),
    .game_en           (game_en),
    .serve             (serve),
    .speed_sel         (speed_sel),
    .left_palette_pos  (left_palette_pos),
    .right_palette_pos (right_palette_pos),
    .ball_xpos         (ball_xpos),
    .ball_ypos         (ball_ypos),
    .score_left        (score_left),
    .score_right       (score_right),
    .in_play           (in_play)
  );

  typedef struct {
    int x;
    int y;
    int play;
    int sl;
    int sr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk   = 1'b0;
  int   sl_cnt = 0;
  int   sr_cnt = 0;

  // Reference model: signed integer ball position and +1/-1 directions
  int m_x, m_y, m_dx, m_dy, m_play, m_sl, m_sr;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts score pulse cycles, compares against the scoreboard at frame end
  always @(negedge clk) begin
    if (score_left === 1'b1)  sl_cnt++;
    if (score_right === 1'b1) sr_cnt++;
    if (chk) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty: got no entry, expected one (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        cmp("ball_xpos",   int'(ball_xpos),   mon_e.x);
        cmp("ball_ypos",   int'(ball_ypos),   mon_e.y);
        cmp("in_play",     int'(in_play),     mon_e.play);
        cmp("score_left",  sl_cnt,            mon_e.sl);
        cmp("score_right", sr_cnt,            mon_e.sr);
      end
      sl_cnt = 0;
      sr_cnt = 0;
    end
  end

  task automatic model_reset();
    m_x = 504; m_y = 376; m_dx = 1; m_dy = 1; m_play = 0;
  endtask

  function automatic bit overlaps(input int by, input int pal);
    return (by + 16 > pal) && (by < pal + 128);
  endfunction

  // One frame of motion as described by the game rules
  task automatic model_step();
    int s;
    s = 2 * (int'(speed_sel) + 1);
    if (m_dy > 0) begin
      if (m_y + s >= 752) begin m_y = 752; m_dy = -1; end
      else m_y = m_y + s;
    end else begin
      if (m_y - s <= 0) begin m_y = 0; m_dy = 1; end
      else m_y = m_y - s;
    end
    if (m_dx > 0) begin
      if (m_x <= 960 && m_x + s >= 960 && overlaps(m_y, int'(right_palette_pos))) begin
        m_x = 960; m_dx = -1;
      end else if (m_x + s >= 1008) begin
        m_sl = 1; m_x = 504; m_y = 376; m_dx = -1; m_play = 0;
      end else m_x = m_x + s;
    end else begin
      if (m_x >= 48 && m_x - s <= 48 && overlaps(m_y, int'(left_palette_pos))) begin
        m_x = 48; m_dx = 1;
      end else if (m_x - s < 0) begin
        m_sr = 1; m_x = 504; m_y = 376; m_dx = 1; m_play = 0;
      end else m_x = m_x - s;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.x = m_x; e.y = m_y; e.play = m_play; e.sl = m_sl; e.sr = m_sr;
    q.push_back(e);
  endtask

  // One 12-cycle frame: vsync high for 4 cycles, optional serve in cycle 6, check in cycle 11
  task automatic run_frame(input bit srv);
    m_sl = 0; m_sr = 0;
    if (m_play != 0 && game_en) model_step();
    if (srv && m_play == 0 && game_en) m_play = 1;
    push_exp();
    for (int c = 0; c < 12; c++) begin
      vsync = (c < 4);
      serve = srv && (c == 6);
      chk   = (c == 11);
      @(posedge clk); #1;
    end
    vsync = 1'b0; serve = 1'b0; chk = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    m_sl = 0; m_sr = 0;
    push_exp();
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [10:0] clamp_pos(input int v);
    if (v < 0)    return 11'd0;
    if (v > 2047) return 11'd2047;
    return 11'(v);
  endfunction

  task automatic track_both(input int jitter);
    int jl, jr;
    jl = (jitter == 0) ? 0 : int'($urandom_range(0, 2 * jitter)) - jitter;
    jr = (jitter == 0) ? 0 : int'($urandom_range(0, 2 * jitter)) - jitter;
    left_palette_pos  = clamp_pos(m_y - 40 + jl);
    right_palette_pos = clamp_pos(m_y - 40 + jr);
  endtask

  initial begin
    bit scored;
    bit srv;
    rst_n = 1'b0; vsync = 1'b0; game_en = 1'b0; serve = 1'b0; speed_sel = 2'd0;
    left_palette_pos = 11'd600; right_palette_pos = 11'd600;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle frames without a serve
    game_en = 1'b1;
    repeat (10) run_frame(1'b0);

    // Slowest serve
    speed_sel = 2'd0;
    run_frame(1'b1);
    repeat (3) run_frame(1'b0);

    // Fast rally with both palettes tracking: bottom wall and right palette clamp
    speed_sel = 2'd3;
    for (int i = 0; i < 120; i++) begin
      track_both(0);
      run_frame(1'b0);
    end

    // Pause mid-flight, serve while in play is ignored, then resume
    game_en = 1'b0;
    repeat (5) run_frame(1'b0);
    game_en = 1'b1;
    track_both(0);
    run_frame(1'b1);
    for (int i = 0; i < 3; i++) begin
      track_both(0);
      run_frame(1'b0);
    end

    // Right palette parked at the top until the ball slips past it
    scored = 1'b0;
    for (int i = 0; i < 300 && !scored; i++) begin
      left_palette_pos  = clamp_pos(m_y - 40);
      right_palette_pos = 11'd0;
      run_frame(1'b0);
      scored = (m_sl != 0);
    end
    cmp("left_miss_reached", int'(scored), 1);
    speed_sel = 2'd0;
    run_frame(1'b1);
    run_frame(1'b0);

    // Reset in the middle of a rally
    run_frame(1'b0);
    run_frame(1'b0);
    do_reset();
    run_frame(1'b0);

    // Randomized play
    game_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      speed_sel = 2'($urandom_range(0, 3));
      game_en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 7) track_both(60);
      else begin
        left_palette_pos  = 11'($urandom_range(0, 2047));
        right_palette_pos = 11'($urandom_range(0, 2047));
      end
      srv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      run_frame(srv);
    end

    repeat (3) @(posedge clk);
    cmp("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
